// File: rtl/clock_time_core_pkg.sv
// Shared clock/display definitions: mode encoding and time-field limits.
// The display driver decodes the same MODE_* values.
package clock_time_defs;

  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_MIN  = 2'd1;
  localparam logic [1:0] MODE_SET_HOUR = 2'd2;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef enum logic [1:0] {
    ST_RUN      = MODE_RUN,
    ST_SET_MIN  = MODE_SET_MIN,
    ST_SET_HOUR = MODE_SET_HOUR
  } mode_e;

  function automatic logic [6:0] wrap_inc7(input logic [6:0] v, input int max);
    return (v == 7'(max)) ? 7'd0 : v + 7'd1;
  endfunction

endpackage

// File: rtl/clock_time_core_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// press pulse on an accepted 0->1 transition of the stable level.
module button_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);
  localparam int              CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn_raw};
      r_press <= 1'b0;
      // Count consecutive disagreeing cycles; any agreement restarts the window.
      if (r_sync[1] != r_stable) begin
        if (r_cnt == CNT_LAST) begin
          r_stable <= r_sync[1];
          r_cnt    <= '0;
          r_press  <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/clock_time_core.sv
// Timekeeping core: seconds prescaler, h/m/s counters and the
// run/set-minute/set-hour mode FSM driven by two debounced buttons.
module clock_time_core
  import clock_time_defs::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [6:0] hour,
  output logic [6:0] minute,
  output logic [5:0] second,
  output logic [1:0] mode,
  output logic       sec_tick
);
  localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(CLK_HZ - 1);

  logic          w_mode_press, w_inc_press;
  logic          w_tick, w_exit_set;
  mode_e         r_state, w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [6:0]    r_hour, r_min;
  logic [5:0]    r_sec;
  logic          r_sec_tick;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_mode), .press(w_mode_press)
  );
  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_inc), .press(w_inc_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_exit_set  = 1'b0;
    if (w_mode_press) begin
      case (r_state)
        ST_RUN:      w_state_nxt = ST_SET_MIN;
        ST_SET_MIN:  w_state_nxt = ST_SET_HOUR;
        ST_SET_HOUR: begin
          w_state_nxt = ST_RUN;
          w_exit_set  = 1'b1;
        end
        default:     w_state_nxt = ST_RUN;
      endcase
    end
  end

  assign w_tick = (r_state == ST_RUN) && (r_presc == PRESC_TOP);

  // Prescaler is frozen outside RUN and restarted on leaving the set states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_presc <= '0;
    else if (w_exit_set)          r_presc <= '0;
    else if (r_state == ST_RUN)   r_presc <= w_tick ? '0 : r_presc + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec      <= '0;
      r_min      <= '0;
      r_hour     <= '0;
      r_sec_tick <= 1'b0;
    end else begin
      r_sec_tick <= w_tick;
      if (w_exit_set) begin
        r_sec <= '0;
      end else if (w_tick) begin
        r_sec <= (r_sec == 6'(SEC_MAX)) ? 6'd0 : r_sec + 6'd1;
        if (r_sec == 6'(SEC_MAX)) begin
          r_min <= wrap_inc7(r_min, MIN_MAX);
          if (r_min == 7'(MIN_MAX)) r_hour <= wrap_inc7(r_hour, HOUR_MAX);
        end
      end else if (w_inc_press && !w_mode_press) begin
        // Setting never carries between fields.
        if (r_state == ST_SET_MIN)  r_min  <= wrap_inc7(r_min, MIN_MAX);
        if (r_state == ST_SET_HOUR) r_hour <= wrap_inc7(r_hour, HOUR_MAX);
      end
    end
  end

  assign hour     = r_hour;
  assign minute   = r_min;
  assign second   = r_sec;
  assign mode     = r_state;
  assign sec_tick = r_sec_tick;

endmodule

// File: tb/tb_clock_time_core.sv
// Randomized self-checking bench for clock_time_core with a small
// time-of-day reference model (total seconds, mode, prescaler phase).
module tb_clock_time_core;
  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;

  logic       clk = 1'b0, rst_n = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [6:0] hour, minute;
  logic [5:0] second;
  logic [1:0] mode;
  logic       sec_tick;

  int total = 0, bad = 0;
  int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_phase = 0;
  bit m_tick = 0;
  int exp_ticks = 0, obs_ticks = 0;

  always #5 clk = ~clk;

  clock_time_core #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hour(hour), .minute(minute), .second(second), .mode(mode), .sec_tick(sec_tick)
  );

  always @(negedge clk) if (sec_tick === 1'b1) obs_ticks++;

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_phase = 0; m_tick = 0;
  endtask

  // One clock edge of the reference: a tick in RUN, then any accepted press.
  task automatic model_edge(input bit pm, input bit pi);
    int t;
    m_tick = 0;
    if (m_mode == 0) begin
      m_phase++;
      if (m_phase == CLK_HZ) begin
        m_phase = 0; m_tick = 1; exp_ticks++;
        t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
        m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
      end
    end
    if (pm) begin
      case (m_mode)
        0:       m_mode = 1;
        1:       m_mode = 2;
        default: begin m_mode = 0; m_s = 0; m_phase = 0; end
      endcase
    end else if (pi) begin
      if (m_mode == 1) m_m = (m_m + 1) % 60;
      else if (m_mode == 2) m_h = (m_h + 1) % 24;
    end
  endtask

  // Called right after a negedge. A hold of DEB+ cycles is accepted DEB+3 edges later.
  task automatic push(input bit bm, input bit bi, input int hold, input int settle);
    btn_mode = bm; btn_inc = bi;
    for (int e = 1; e <= hold + settle; e++) begin
      @(posedge clk);
      model_edge(hold >= DEB && e == DEB + 3 && bm, hold >= DEB && e == DEB + 3 && bi);
      @(negedge clk);
      if (e == hold) begin btn_mode = 1'b0; btn_inc = 1'b0; end
    end
  endtask

  task automatic idle(input int n);
    for (int e = 0; e < n; e++) begin
      @(posedge clk); model_edge(0, 0); @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (hour !== 7'd0)   begin bad++; $display("FAIL reset_hour got=%0d exp=0", hour); end
    total++; if (minute !== 7'd0) begin bad++; $display("FAIL reset_minute got=%0d exp=0", minute); end
    total++; if (second !== 6'd0) begin bad++; $display("FAIL reset_second got=%0d exp=0", second); end
    total++; if (mode !== 2'd0)   begin bad++; $display("FAIL reset_mode got=%0d exp=0", mode); end
    total++; if (sec_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%0b exp=0", sec_tick); end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_ticks();
    rst_n = 1'b1; model_reset(); exp_ticks = 0; obs_ticks = 0;
    for (int e = 1; e <= 600; e++) begin
      @(posedge clk); model_edge(0, 0); @(negedge clk);
      total++;
      if (int'(second) !== (e / 10) % 60) begin
        bad++; $display("FAIL tick_second cyc=%0d got=%0d exp=%0d", e, second, (e / 10) % 60);
      end
      total++;
      if (sec_tick !== (e % 10 == 0)) begin
        bad++; $display("FAIL tick_pulse cyc=%0d got=%0b exp=%0b", e, sec_tick, (e % 10 == 0));
      end
    end
    #1;
    total++; if (hour !== 7'd0 || minute !== 7'd1 || second !== 6'd0) begin
      bad++; $display("FAIL tick_final got=%0d:%0d:%0d exp=0:1:0", hour, minute, second);
    end
    total++; if (obs_ticks !== 60) begin
      bad++; $display("FAIL tick_count got=%0d exp=60", obs_ticks);
    end
  endtask

  task automatic test_minute();
    int start, prev;
    idle($urandom_range(0, 15));
    push(1, 0, 8, 8);
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL min_mode got=%0d exp=1", mode); end
    start = m_m;
    for (int k = 0; k < 61; k++) begin
      prev = int'(minute);
      push(0, 1, $urandom_range(8, 12), $urandom_range(8, 10));
      total++;
      if (int'(minute) !== m_m || int'(hour) !== m_h || int'(second) !== m_s || mode !== 2'd1) begin
        bad++; $display("FAIL min_step k=%0d got=%0d:%0d:%0d m%0d exp=%0d:%0d:%0d m1",
                        k, hour, minute, second, mode, m_h, m_m, m_s);
      end
      if (prev == 59) begin
        total++; if (minute !== 7'd0) begin bad++; $display("FAIL min_wrap got=%0d exp=0", minute); end
      end
    end
    total++; if (int'(minute) !== (start + 61) % 60) begin
      bad++; $display("FAIL min_final got=%0d exp=%0d", minute, (start + 61) % 60);
    end
  endtask

  task automatic test_hour();
    int start;
    while (m_mode != 2) push(1, 0, 8, 8);
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL hour_mode got=%0d exp=2", mode); end
    start = m_h;
    for (int k = 0; k < 25; k++) push(0, 1, $urandom_range(8, 12), 8);
    total++; if (int'(hour) !== (start + 25) % 24 || int'(minute) !== m_m) begin
      bad++; $display("FAIL hour_final got=%0d:%0d exp=%0d:%0d", hour, minute, (start + 25) % 24, m_m);
    end
    btn_mode = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); model_edge(e == DEB + 3, 0); @(negedge clk);
      if (e == 8) btn_mode = 1'b0;
      if (e == 7) begin
        total++; if (mode !== 2'd0 || second !== 6'd0) begin
          bad++; $display("FAIL hour_exit got=m%0d s%0d exp=m0 s0", mode, second);
        end
      end
      if (e > 7) begin
        total++; if (sec_tick !== (e == 17)) begin
          bad++; $display("FAIL exit_tick cyc=%0d got=%0b exp=%0b", e, sec_tick, (e == 17));
        end
      end
    end
    total++; if (int'(second) !== m_s || m_s != 1) begin
      bad++; $display("FAIL exit_second got=%0d exp=1", second);
    end
  endtask

  task automatic test_rollover();
    bit prev_last = 0, seen = 0;
    push(1, 0, 8, 8);
    while (m_m != 59) push(0, 1, 8, 8);
    push(1, 0, 8, 8);
    while (m_h != 23) push(0, 1, 8, 8);
    push(1, 0, 8, 8);
    for (int e = 1; e <= 600; e++) begin
      @(posedge clk); model_edge(0, 0); @(negedge clk);
      total++;
      if (int'(hour) !== m_h || int'(minute) !== m_m || int'(second) !== m_s || mode !== 2'd0) begin
        bad++; $display("FAIL roll_step cyc=%0d got=%0d:%0d:%0d m%0d exp=%0d:%0d:%0d m0",
                        e, hour, minute, second, mode, m_h, m_m, m_s);
      end
      if (prev_last && hour === 7'd0 && minute === 7'd0 && second === 6'd0) seen = 1;
      prev_last = (hour === 7'd23 && minute === 7'd59 && second === 6'd59);
    end
    total++; if (!seen) begin bad++; $display("FAIL roll_midnight got=0 exp=1"); end
  endtask

  task automatic test_bounce();
    int m0;
    push(1, 0, 8, 8);
    m0 = m_m;
    repeat (5) push(0, 1, $urandom_range(1, 3), $urandom_range(2, 4));
    push(0, 1, 3, 8);
    total++; if (int'(minute) !== m0 || mode !== 2'd1) begin
      bad++; $display("FAIL bounce_reject got=%0d m%0d exp=%0d m1", minute, mode, m0);
    end
    btn_inc = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); model_edge(0, e == DEB + 3); @(negedge clk);
      if (e == 8) btn_inc = 1'b0;
      total++;
      if (int'(minute) !== ((e >= 7) ? (m0 + 1) % 60 : m0)) begin
        bad++; $display("FAIL bounce_latency cyc=%0d got=%0d exp=%0d",
                        e, minute, (e >= 7) ? (m0 + 1) % 60 : m0);
      end
    end
  endtask

  task automatic test_priority();
    int m0, h0;
    m0 = m_m; h0 = m_h;
    push(1, 1, 8, 8);
    total++; if (mode !== 2'd2 || int'(minute) !== m0 || int'(hour) !== h0) begin
      bad++; $display("FAIL priority got=m%0d %0d:%0d exp=m2 %0d:%0d", mode, hour, minute, h0, m0);
    end
  endtask

  task automatic test_reset_mid();
    btn_inc = 1'b1;
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    total++; if (hour !== 7'd0 || minute !== 7'd0 || second !== 6'd0 || mode !== 2'd0 || sec_tick !== 1'b0) begin
      bad++; $display("FAIL reset_async got=%0d:%0d:%0d m%0d t%0b exp=0:0:0 m0 t0",
                      hour, minute, second, mode, sec_tick);
    end
    model_reset();
    btn_mode = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); model_edge(0, 0); @(negedge clk);
      if (e == 2) btn_mode = 1'b0;
      total++;
      if (mode !== 2'd0 || int'(hour) !== m_h || int'(minute) !== m_m || int'(second) !== m_s) begin
        bad++; $display("FAIL post_reset cyc=%0d got=%0d:%0d:%0d m%0d exp=%0d:%0d:%0d m0",
                        e, hour, minute, second, mode, m_h, m_m, m_s);
      end
    end
    btn_inc = 1'b0;
    idle(10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ticks();
    test_minute();
    test_hour();
    test_rollover();
    test_bounce();
    test_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_time_core.md
# clock_time_core

Timekeeping and user-setting stage that feeds the 4-digit 7-segment display driver. Keeps hours/minutes/seconds from the 50 MHz system clock and runs a run/set-minute/set-hour mode FSM driven by two debounced push-buttons. Drives the display's `hour`, `minute` and `mode` inputs directly, using the display's mode encoding.

## Interface
- `CLK_HZ`, 50_000_000, clock cycles per second; the prescaler wraps at `CLK_HZ-1`.
- `DEBOUNCE_CYC`, 1_000_000, consecutive stable cycles needed to accept a button level (20 ms).
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_mode`  in  1  raw, asynchronous, active-high mode button.
- `btn_inc`  in  1  raw, asynchronous, active-high increment button.
- `hour`  out  7  0..23, binary, registered.
- `minute`  out  7  0..59, binary, registered.
- `second`  out  6  0..59, binary, registered.
- `mode`  out  2  0 = RUN, 1 = SET_MIN, 2 = SET_HOUR; value 3 is never driven.
- `sec_tick`  out  1  one-cycle pulse on each seconds advance in RUN.

## Operation
- **Reset (rst_n low):** `hour` = 0, `minute` = 0, `second` = 0, `mode` = RUN, `sec_tick` = 0, prescaler = 0, debouncers stable-low with counters at 0. All outputs reach these values immediately, without waiting for `clk`.
- **Prescaler:** counts 0..`CLK_HZ-1` in RUN only. At `CLK_HZ-1` it wraps to 0 and issues one tick.
- **Tick in RUN:**
  - `second` increments. 59 → 0 carries into `minute`.
  - `minute` 59 → 0 carries into `hour`.
  - `hour` 23 → 0.
  - A full carry moves 23:59:59 to 00:00:00 in one cycle.
- **Mode FSM:** a `mode` press moves RUN → SET_MIN → SET_HOUR → RUN.
  - On entry to SET_MIN, the prescaler and `second` freeze.
  - On SET_HOUR → RUN, `second` ← 0 and prescaler ← 0, so the first tick arrives `CLK_HZ` cycles later.
- **Increment press:**
  - SET_MIN: `minute` ← (`minute`==59) ? 0 : `minute`+1. No carry into `hour`.
  - SET_HOUR: `hour` ← (`hour`==23) ? 0 : `hour`+1.
  - RUN: ignored.
- **Simultaneous events:** a mode press and an inc press in the same cycle: the mode press is applied and the inc press is dropped. A tick cannot coincide with a press in a SET state, because ticks occur only in RUN.
- **Debounce (per button):**
  - 2-FF synchronizer feeds a counter of consecutive cycles where the synced value ≠ the stable level.
  - The counter clears on any agreement. When it reaches `DEBOUNCE_CYC-1`, the stable level flips.
  - A press pulse is one cycle, on a stable 0 → 1 only. Releases generate nothing.
  - Holding a button gives exactly one press, with no auto-repeat.
  - Bounce shorter than `DEBOUNCE_CYC` produces no pulse.

## Timing
- Button edge to output change: `DEBOUNCE_CYC`+3 `clk` edges (2 sync + stable flip + FSM register), with ±1 cycle for asynchronous input sampling.
- Tick to `second`/`minute`/`hour` update: the same edge that wraps the prescaler. `sec_tick` is high during the cycle after that edge, aligned with the new `second`.
- In RUN, `sec_tick` period is exactly `CLK_HZ` cycles.
- Reset asserted mid-debounce or mid-setting discards all progress. There is no pulse after reset release until a fresh, full `DEBOUNCE_CYC` stable-high window.

## Structure
- Shared defines header `clock_time_defs`:
  - mode constants `MODE_RUN`/`MODE_SET_MIN`/`MODE_SET_HOUR`;
  - limits `SEC_MAX`=59, `MIN_MAX`=59, `HOUR_MAX`=23.
  - The display block uses the same mode constants.
- One sub-module, `button_debounce` (params `DEBOUNCE_CYC`; ports `clk`, `rst_n`, `btn_raw`, `press`), instantiated twice.
- Counter width is derived from the parameter via `$clog2`.

## Test plan
Bench uses `CLK_HZ`=10, `DEBOUNCE_CYC`=4.
- **Reset and ticks:** reset, release, run 600 cycles → `second` advances every 10 cycles, reaching 0:01:00 at cycle 600; `sec_tick` count = 60.
- **Full rollover:** preload via set mode to 23:59, return to RUN, run 600 cycles → 00:00:00 in a single cycle, `mode`=0.
- **Minute setting:** press `mode` once, then `inc` 61 times with a clean 8-cycle hold each → `mode`=1, `minute` wraps 59 → 0 with `hour` unchanged, `second` frozen.
- **Hour setting and exit:** press `mode` twice, `inc` 25 times → `hour` = (start+25) mod 24; press `mode` → `mode`=0, `second`=0, first `sec_tick` 10 cycles later.
- **Bounce rejection:** 3-cycle glitches on `btn_inc` in SET_MIN, then a 3-cycle hold → no change. An 8-cycle hold → exactly one increment, 7 cycles (±1) after the edge.
- **Priority and reset:** `mode` and `inc` stable-high on the same cycle in SET_MIN → `mode`=2, `minute` unchanged. Assert `rst_n` low mid-hold → all outputs 0 immediately, and no press is seen after release while the button stays high.
